// File: rtl/rv_decode_pkg.sv
// Shared RV32I decode constants: opcodes, format codes, field positions and the
// buffered field bundle carried through the decode stage.
package rv_decode_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    localparam int unsigned OPCODE_LSB = 0;
    localparam int unsigned RD_LSB     = 7;
    localparam int unsigned FUNCT3_LSB = 12;
    localparam int unsigned RS1_LSB    = 15;
    localparam int unsigned RS2_LSB    = 20;
    localparam int unsigned FUNCT7_LSB = 25;

    localparam int unsigned OPCODE_W = 7;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned FUNCT3_W = 3;
    localparam int unsigned FUNCT7_W = 7;

    typedef struct packed {
        logic [FUNCT7_W-1:0] funct7;
        logic [REG_W-1:0]    rs2;
        logic [REG_W-1:0]    rs1;
        logic [FUNCT3_W-1:0] funct3;
        logic [REG_W-1:0]    rd;
        logic [OPCODE_W-1:0] opcode;
        logic [2:0]          fmt;
        logic                illegal;
    } dec_fields_t;

    function automatic dec_fields_t split_fields(input logic [31:0] instr,
                                                 input logic [2:0]  fmt,
                                                 input logic        illegal);
        dec_fields_t f;
        f.funct7  = instr[FUNCT7_LSB +: FUNCT7_W];
        f.rs2     = instr[RS2_LSB +: REG_W];
        f.rs1     = instr[RS1_LSB +: REG_W];
        f.funct3  = instr[FUNCT3_LSB +: FUNCT3_W];
        f.rd      = instr[RD_LSB +: REG_W];
        f.opcode  = instr[OPCODE_LSB +: OPCODE_W];
        f.fmt     = fmt;
        f.illegal = illegal;
        return f;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I format classifier and immediate generator; the 32-bit
// immediate is sign-extended to XLEN.
module imm_gen
    import rv_decode_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     instr_i,
    output logic [XLEN-1:0] imm_o,
    output logic [2:0]      fmt_o,
    output logic            illegal_o
);

    logic [OPCODE_W-1:0] opcode;
    logic [31:0]         imm32;

    assign opcode = instr_i[OPCODE_LSB +: OPCODE_W];

    always_comb begin
        fmt_o     = FMT_R;
        illegal_o = 1'b0;
        if (instr_i[1:0] != 2'b11) begin
            illegal_o = 1'b1;
        end else begin
            case (opcode)
                OPC_LUI, OPC_AUIPC:                                  fmt_o = FMT_U;
                OPC_JAL:                                             fmt_o = FMT_J;
                OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_FENCE, OPC_SYSTEM: fmt_o = FMT_I;
                OPC_BRANCH:                                          fmt_o = FMT_B;
                OPC_STORE:                                           fmt_o = FMT_S;
                OPC_OP:                                              fmt_o = FMT_R;
                default:                                             illegal_o = 1'b1;
            endcase
        end
    end

    // Illegal words fall through with fmt_o still FMT_R, so they get imm = 0.
    always_comb begin
        imm32 = '0;
        case (fmt_o)
            FMT_I: imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            FMT_S: imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            FMT_B: imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                            instr_i[11:8], 1'b0};
            FMT_U: imm32 = {instr_i[31:12], 12'b0};
            FMT_J: imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                            instr_i[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: decodes in front of a main + skid buffer pair so in_ready
// is registered and full throughput is kept under downstream backpressure.
module decode_stage
    import rv_decode_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [6:0]       opcode,
    output logic [4:0]       rd,
    output logic [2:0]       funct3,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [6:0]       funct7,
    output logic [XLEN-1:0]  imm,
    output logic [2:0]       fmt,
    output logic             illegal,
    output logic [XLEN-1:0]  out_pc,
    output logic [CNT_W-1:0] decode_cnt
);

    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;
    logic            dec_illegal;
    dec_fields_t     dec_fields;

    imm_gen #(
        .XLEN(XLEN)
    ) u_imm_gen (
        .instr_i  (in_instr),
        .imm_o    (dec_imm),
        .fmt_o    (dec_fmt),
        .illegal_o(dec_illegal)
    );

    assign dec_fields = split_fields(in_instr, dec_fmt, dec_illegal);

    logic             main_valid_q, main_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic             in_ready_q, in_ready_d;
    dec_fields_t      main_f_q, main_f_d;
    dec_fields_t      skid_f_q, skid_f_d;
    logic [XLEN-1:0]  main_imm_q, main_imm_d;
    logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
    logic [XLEN-1:0]  main_pc_q, main_pc_d;
    logic [XLEN-1:0]  skid_pc_q, skid_pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic accept;
    logic out_fire;

    assign accept   = in_valid & in_ready_q;
    assign out_fire = main_valid_q & out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_f_d     = main_f_q;
        skid_f_d     = skid_f_q;
        main_imm_d   = main_imm_q;
        skid_imm_d   = skid_imm_q;
        main_pc_d    = main_pc_q;
        skid_pc_d    = skid_pc_q;
        cnt_d        = cnt_q;

        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            if (out_fire) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (out_fire || !main_valid_q) begin
                // accept cannot coincide with a full skid: in_ready_q is low then.
                if (skid_valid_q) begin
                    main_valid_d = 1'b1;
                    main_f_d     = skid_f_q;
                    main_imm_d   = skid_imm_q;
                    main_pc_d    = skid_pc_q;
                    skid_valid_d = 1'b0;
                end else if (accept) begin
                    main_valid_d = 1'b1;
                    main_f_d     = dec_fields;
                    main_imm_d   = dec_imm;
                    main_pc_d    = in_pc;
                end else begin
                    main_valid_d = 1'b0;
                end
            end else if (accept) begin
                skid_valid_d = 1'b1;
                skid_f_d     = dec_fields;
                skid_imm_d   = dec_imm;
                skid_pc_d    = in_pc;
            end
        end

        in_ready_d = ~skid_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
            main_f_q     <= '0;
            skid_f_q     <= '0;
            main_imm_q   <= '0;
            skid_imm_q   <= '0;
            main_pc_q    <= '0;
            skid_pc_q    <= '0;
            cnt_q        <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            main_f_q     <= main_f_d;
            skid_f_q     <= skid_f_d;
            main_imm_q   <= main_imm_d;
            skid_imm_q   <= skid_imm_d;
            main_pc_q    <= main_pc_d;
            skid_pc_q    <= skid_pc_d;
            cnt_q        <= cnt_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = main_valid_q;
    assign opcode     = main_f_q.opcode;
    assign rd         = main_f_q.rd;
    assign funct3     = main_f_q.funct3;
    assign rs1        = main_f_q.rs1;
    assign rs2        = main_f_q.rs2;
    assign funct7     = main_f_q.funct7;
    assign fmt        = main_f_q.fmt;
    assign illegal    = main_f_q.illegal;
    assign imm        = main_imm_q;
    assign out_pc     = main_pc_q;
    assign decode_cnt = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus a randomized
// stream checked against a queue-based reference model.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        illegal;
    logic [31:0] out_pc;
    logic [31:0] decode_cnt;

    int checks = 0;
    int errors = 0;

    decode_stage #(
        .XLEN (32),
        .CNT_W(32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .opcode    (opcode),
        .rd        (rd),
        .funct3    (funct3),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct7    (funct7),
        .imm       (imm),
        .fmt       (fmt),
        .illegal   (illegal),
        .out_pc    (out_pc),
        .decode_cnt(decode_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } item_t;

    // Reference decode from the ISA immediate rules, using signed arithmetic.
    function automatic void ref_decode(input logic [31:0] w, output logic [2:0] f,
                                       output logic [31:0] im, output logic il);
        longint s;
        longint r;
        s  = longint'($signed(w));
        r  = 0;
        f  = 3'd0;
        il = 1'b0;
        case (w[6:0])
            7'h33: f = 3'd0;
            7'h13, 7'h03, 7'h67, 7'h0F, 7'h73: begin
                f = 3'd1;
                r = s >>> 20;
            end
            7'h23: begin
                f = 3'd2;
                r = ((s >>> 25) * 32) + longint'(w[11:7]);
            end
            7'h63: begin
                f = 3'd3;
                r = ((s >>> 31) * 4096) + longint'(w[7]) * 2048 + longint'(w[30:25]) * 32
                    + longint'(w[11:8]) * 2;
            end
            7'h37, 7'h17: begin
                f = 3'd4;
                r = (s >>> 12) * 4096;
            end
            7'h6F: begin
                f = 3'd5;
                r = ((s >>> 31) * 1048576) + longint'(w[19:12]) * 4096
                    + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2;
            end
            default: il = 1'b1;
        endcase
        im = r[31:0];
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  tab [11];
        logic [31:0] w;
        tab = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
        w = $urandom;
        if ($urandom_range(7) != 0) w[6:0] = tab[$urandom_range(10)];
        return w;
    endfunction

    task automatic apply_reset();
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks += 6;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
        if (decode_cnt !== 32'd0) begin errors++; $display("FAIL rst_cnt got=%0d exp=0", decode_cnt); end
        if ({opcode, rd, funct3, rs1, rs2, funct7} !== '0) begin
            errors++; $display("FAIL rst_fields got=%h exp=0", {opcode, rd, funct3, rs1, rs2, funct7});
        end
        if ({imm, fmt, illegal} !== '0) begin errors++; $display("FAIL rst_imm got=%h exp=0", {imm, fmt, illegal}); end
        if (out_pc !== 32'd0) begin errors++; $display("FAIL rst_pc got=%h exp=0", out_pc); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_rel_ready got=%b exp=0", in_ready); end
        @(posedge clk);
        #1;
        checks += 2;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_first_clk_ready got=%b exp=1", in_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_first_clk_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_r_type();
        in_valid = 1'b1;
        in_instr = 32'h40628533;
        in_pc    = 32'h0000_1000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks += 5;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL r_valid got=%b exp=1", out_valid); end
        if ({opcode, rd, rs1, rs2} !== {7'b0110011, 5'd10, 5'd5, 5'd6}) begin
            errors++; $display("FAIL r_regs got=%b/%0d/%0d/%0d exp=0110011/10/5/6", opcode, rd, rs1, rs2);
        end
        if ({funct3, funct7} !== {3'd0, 7'b0100000}) begin
            errors++; $display("FAIL r_funct got=%0d/%b exp=0/0100000", funct3, funct7);
        end
        if ({fmt, imm, illegal} !== {3'd0, 32'd0, 1'b0}) begin
            errors++; $display("FAIL r_fmt got=%0d/%h/%b exp=0/0/0", fmt, imm, illegal);
        end
        if (out_pc !== 32'h1000) begin errors++; $display("FAIL r_pc got=%h exp=1000", out_pc); end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL r_drain got=%b exp=0", out_valid); end
        if (decode_cnt !== 32'd1) begin errors++; $display("FAIL r_cnt got=%0d exp=1", decode_cnt); end
    endtask

    task automatic test_imm_vectors();
        logic [31:0] ins [3];
        logic [31:0] eimm [3];
        logic [2:0]  efmt [3];
        ins  = '{32'hFFF00093, 32'h123452B7, 32'hFE000EE3};
        eimm = '{32'hFFFFFFFF, 32'h12345000, 32'hFFFFFFFC};
        efmt = '{3'd1, 3'd4, 3'd3};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_instr = ins[i];
            in_pc    = 32'h2000 + 32'(i * 4);
            @(posedge clk);
            #1;
            checks += 3;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL imm%0d_valid got=%b exp=1", i, out_valid); end
            if (imm !== eimm[i]) begin errors++; $display("FAIL imm%0d_val got=%h exp=%h", i, imm, eimm[i]); end
            if (fmt !== efmt[i]) begin errors++; $display("FAIL imm%0d_fmt got=%0d exp=%0d", i, fmt, efmt[i]); end
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (decode_cnt !== 32'd4) begin errors++; $display("FAIL imm_cnt got=%0d exp=4", decode_cnt); end
    endtask

    task automatic test_illegal();
        in_valid = 1'b1;
        in_instr = 32'h0000_0000;
        in_pc    = 32'h3000;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks += 2;
        if ({out_valid, illegal} !== 2'b11) begin
            errors++; $display("FAIL ill_flag got=%b%b exp=11", out_valid, illegal);
        end
        if ({fmt, imm} !== '0) begin errors++; $display("FAIL ill_fmt got=%0d/%h exp=0/0", fmt, imm); end
        @(posedge clk);
        #1;
        checks++;
        if (decode_cnt !== 32'd5) begin errors++; $display("FAIL ill_cnt got=%0d exp=5", decode_cnt); end
    endtask

    task automatic test_back_to_back();
        item_t       list [6];
        int          idx = 0;
        int          got = 0;
        int          cyc = 0;
        logic [2:0]  ef;
        logic [31:0] ei;
        logic        el;
        logic        acc;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            list[i].instr = rand_instr();
            list[i].pc    = 32'h8000 + 32'(i * 4);
        end
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            in_instr = list[idx].instr;
            in_pc    = list[idx].pc;
            #3;
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) idx++;
        end
        checks += 3;
        if (idx !== 2) begin errors++; $display("FAIL b2b_accepts got=%0d exp=2", idx); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall_ready got=%b exp=0", in_ready); end
        if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_stall_valid got=%b exp=1", out_valid); end
        out_ready = 1'b1;
        while (got < 6 && cyc < 30) begin
            in_valid = (idx < 6);
            if (idx < 6) begin
                in_instr = list[idx].instr;
                in_pc    = list[idx].pc;
            end
            #3;
            acc = in_valid && in_ready;
            if (out_valid) begin
                ref_decode(list[got].instr, ef, ei, el);
                checks++;
                if (out_pc !== list[got].pc || imm !== ei || fmt !== ef || rd !== list[got].instr[11:7]) begin
                    errors++;
                    $display("FAIL b2b_order item=%0d got pc=%h imm=%h exp pc=%h imm=%h",
                             got, out_pc, imm, list[got].pc, ei);
                end
                got++;
            end
            @(posedge clk);
            #1;
            if (acc) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        checks += 3;
        if (got !== 6) begin errors++; $display("FAIL b2b_delivered got=%0d exp=6", got); end
        if (decode_cnt !== 32'd6) begin errors++; $display("FAIL b2b_cnt got=%0d exp=6", decode_cnt); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_flush();
        apply_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00A00513;
        in_pc     = 32'h4000;
        repeat (2) @(posedge clk);
        #1;
        checks += 2;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_full_ready got=%b exp=0", in_ready); end
        if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_full_valid got=%b exp=1", out_valid); end
        flush     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        checks += 3;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got=%b exp=1", in_ready); end
        if (decode_cnt !== 32'd0) begin errors++; $display("FAIL flush_cnt got=%0d exp=0", decode_cnt); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'hFFF00093;
        in_pc     = 32'h5000;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks += 4;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL arst_hs got=%b%b exp=00", out_valid, in_ready);
        end
        if (decode_cnt !== 32'd0) begin errors++; $display("FAIL arst_cnt got=%0d exp=0", decode_cnt); end
        if (imm !== 32'd0 || out_pc !== 32'd0) begin
            errors++; $display("FAIL arst_data got=%h/%h exp=0/0", imm, out_pc);
        end
        if ({opcode, rd, fmt} !== '0) begin errors++; $display("FAIL arst_fields got=%h exp=0", {opcode, rd, fmt}); end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL arst_rel_ready got=%b exp=0", in_ready); end
        @(posedge clk);
        #1;
        checks += 2;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL arst_clk_ready got=%b exp=1", in_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_clk_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_random();
        item_t       q [$];
        item_t       it;
        int          exp_cnt = 0;
        logic [2:0]  ef;
        logic [31:0] ei;
        logic        el;
        logic        fire;
        logic        acc;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            checks += 3;
            if (out_valid !== (q.size() > 0)) begin
                errors++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", c, out_valid, q.size() > 0);
            end
            if (in_ready !== (q.size() < 2)) begin
                errors++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", c, in_ready, q.size() < 2);
            end
            if (decode_cnt !== 32'(exp_cnt)) begin
                errors++; $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", c, decode_cnt, exp_cnt);
            end
            if (q.size() > 0) begin
                ref_decode(q[0].instr, ef, ei, el);
                checks++;
                if (imm !== ei || fmt !== ef || illegal !== el || out_pc !== q[0].pc
                    || opcode !== q[0].instr[6:0] || rs1 !== q[0].instr[19:15]
                    || funct7 !== q[0].instr[31:25] || funct3 !== q[0].instr[14:12]) begin
                    errors++;
                    $display("FAIL rnd_data cyc=%0d got imm=%h fmt=%0d ill=%b pc=%h exp imm=%h fmt=%0d ill=%b pc=%h",
                             c, imm, fmt, illegal, out_pc, ei, ef, el, q[0].pc);
                end
            end
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            flush     = ($urandom_range(31) == 0);
            in_instr  = rand_instr();
            in_pc     = $urandom;
            fire = (q.size() > 0) && out_ready;
            acc  = in_valid && (q.size() < 2);
            @(posedge clk);
            #1;
            if (flush) begin
                q.delete();
            end else begin
                if (fire) begin
                    void'(q.pop_front());
                    exp_cnt++;
                end
                if (acc) begin
                    it.instr = in_instr;
                    it.pc    = in_pc;
                    q.push_back(it);
                end
            end
        end
        flush    = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_r_type();
        test_imm_vectors();
        test_illegal();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, default 32, meaning datapath width of pc and imm, legal values 32 or 64.
REQ-002 Parameter CNT_W, default 32, meaning width of the retired-decode counter.
REQ-003 Port clk, input, 1, meaning the single clock; all state updates on the rising edge.
REQ-004 Port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-005 Port flush, input, 1, meaning synchronous discard of all buffered instructions.
REQ-006 Port in_valid, input, 1, meaning an upstream instruction is offered.
REQ-007 Port in_ready, output, 1, meaning the stage accepts an instruction this cycle.
REQ-008 Port in_instr, input, 32, meaning the raw RV32I instruction word.
REQ-009 Port in_pc, input, XLEN, meaning the instruction address.
REQ-010 Port out_valid, input/output pair: out_valid output 1 and out_ready input 1, meaning the downstream handshake.
REQ-011 Output ports opcode 7, rd 5, funct3 3, rs1 5, rs2 5, funct7 7, meaning the raw instruction fields.
REQ-012 Output ports imm XLEN, fmt 3, illegal 1, out_pc XLEN, meaning sign-extended immediate, format code, illegal flag and pc passthrough.
REQ-013 Output port decode_cnt, CNT_W, meaning the count of completed output handshakes.

Function
REQ-014 Input transfer occurs when in_valid and in_ready are both 1; output transfer when out_valid and out_ready are both 1.
REQ-015 Latency is exactly one cycle: an instruction accepted in cycle N is presented with out_valid=1 in cycle N+1.
REQ-016 Buffering is two entries, a main output register plus one skid register, giving full throughput with no combinational path from out_ready to in_ready.
REQ-017 in_ready is 1 only when the skid register is empty; in_ready is a registered signal.
REQ-018 An accept while the main register holds an instruction and out_ready is 0 loads the skid register.
REQ-019 On an output transfer, a valid skid entry moves to the main register in the same edge, and the skid register empties.
REQ-020 A simultaneous input and output transfer with the skid empty replaces the main register with the new instruction.
REQ-021 Output fields stay stable while out_valid=1 and out_ready=0.
REQ-022 fmt encodes R=0, I=1, S=2, B=3, U=4, J=5. Values 6 and 7 are unused.
REQ-023 Immediates are sign-extended to XLEN: I from bits 31:20; S from 31:25 and 11:7; B as {31,7,30:25,11:8,0}; U as {31:12,12'b0}; J as {31,19:12,20,30:21,0}; imm is 0 for R.
REQ-024 illegal is 1 when bits 1:0 are not 2'b11 or the opcode is not one of LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, FENCE or SYSTEM; an illegal instruction still flows with fmt=R and imm=0.
REQ-025 flush has priority over any transfer in the same cycle: both entries are invalidated, out_valid=0 and in_ready=1 in the next cycle, and the counter does not increment for that cycle.
REQ-026 decode_cnt increments by 1 on each output transfer and wraps modulo 2^CNT_W.

Reset
REQ-027 While rst_n=0, out_valid=0, the skid register is empty, in_ready=0, decode_cnt=0 and all field, imm, fmt, illegal and out_pc registers are 0.
REQ-028 in_ready rises in the first clock after rst_n deasserts; reset asserted mid-transfer discards all buffered instructions.

Structure
REQ-029 Shared package rv_decode_pkg holds the opcode localparams, the fmt encoding constants and the field bit-position constants.
REQ-030 One combinational sub-module imm_gen(instr -> imm, fmt, illegal) is instantiated once, in front of the buffer, with parameter XLEN.

Verification
REQ-031 Accept 0x40628533 -> next cycle: opcode=0110011, rd=10, rs1=5, rs2=6, funct3=0, funct7=0100000, fmt=0, imm=0, illegal=0.
REQ-032 Instructions 0xFFF00093, 0x123452B7 and 0xFE000EE3 -> imm=0xFFFFFFFF with fmt=1, then imm=0x12345000 with fmt=4, then imm=0xFFFFFFFC with fmt=3.
REQ-033 Instruction 0x00000000 -> illegal=1, fmt=0, imm=0, out_valid=1.
REQ-034 Back-to-back stream with out_ready held 0 for 3 cycles -> exactly two entries accepted, in_ready=0 thereafter, no loss, duplication or reordering once out_ready=1, and decode_cnt equals the number of output transfers.
REQ-035 flush asserted with both entries full and out_ready=1 -> out_valid=0 next cycle and decode_cnt unchanged.
REQ-036 rst_n pulsed low asynchronously mid-stream -> all outputs 0 immediately, and in_ready=1 one clock after release.
